// File: rtl/sdram_access_arbiter.sv
// Shares one Avalon-MM SDRAM port between the display line fetcher (prioritised
// burst reads, bounded outstanding) and the frame writer (single-word writes).
module sdram_access_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 32,
  parameter int BURST_W  = 10,
  parameter int MAX_PEND = 7,
  parameter int WR_SLOT  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_req,
  input  logic [ADDR_W-1:0]     disp_addr,
  input  logic [BURST_W-1:0]    disp_len,
  output logic                  disp_busy,
  output logic [DATA_W-1:0]     disp_data,
  output logic                  disp_valid,
  output logic                  disp_done,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  output logic                  wr_ack,
  output logic [ADDR_W-1:0]     av_address,
  output logic                  av_read,
  output logic                  av_write,
  output logic [DATA_W-1:0]     av_writedata,
  output logic [DATA_W/8-1:0]   av_byteenable,
  input  logic                  av_waitrequest,
  input  logic [DATA_W-1:0]     av_readdata,
  input  logic                  av_readdatavalid
);
  localparam int CNT_W  = BURST_W + 1;
  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0]  SLOT_MAX = CNT_W'(WR_SLOT);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_ISSUE, RD_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    len_q, issued_q, received_q, slot_q;
  logic [PEND_W-1:0]   pend_q;
  logic                busy_q, done_q, valid_q, ack_q;
  logic [DATA_W-1:0]   data_q;

  logic                rd_fire, wr_fire, ret_ok, wr_seen;
  logic                burst_start, len_zero, drain_exit;
  logic [CNT_W-1:0]    issued_inc, slot_inc;

  assign rd_fire     = av_read & ~av_waitrequest;
  assign wr_fire     = av_write & ~av_waitrequest;
  // Returns with no burst or nothing outstanding are stale and dropped.
  assign ret_ok      = av_readdatavalid & busy_q & (pend_q != '0);
  // The requester still holds wr_req during the ack cycle, so it is masked there.
  assign wr_seen     = wr_req & ~ack_q;
  assign burst_start = (state_q == IDLE) & disp_req;
  assign len_zero    = (disp_len == '0);
  assign drain_exit  = (state_q == RD_DRAIN) & (received_q == len_q);
  assign issued_inc  = issued_q + CNT_W'(1);
  assign slot_inc    = (slot_q < SLOT_MAX) ? slot_q + CNT_W'(1) : slot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (disp_req)     state_d = len_zero ? IDLE : RD_ISSUE;
        else if (wr_seen) state_d = WR_ISSUE;
      end
      RD_ISSUE: begin
        if (rd_fire) begin
          if ((slot_inc == SLOT_MAX) && wr_seen) state_d = WR_ISSUE;
          else if (issued_inc == len_q)          state_d = RD_DRAIN;
        end
      end
      WR_ISSUE: begin
        if (wr_fire) begin
          if (!busy_q)               state_d = IDLE;
          else if (issued_q != len_q) state_d = RD_ISSUE;
          else                        state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (received_q == len_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    av_read       = 1'b0;
    av_write      = 1'b0;
    av_address    = '0;
    av_writedata  = '0;
    av_byteenable = '0;
    case (state_q)
      RD_ISSUE: begin
        av_read    = (pend_q < PEND_MAX) && (issued_q != len_q);
        av_address = base_q + ADDR_W'(issued_q);
      end
      WR_ISSUE: begin
        av_write      = 1'b1;
        av_address    = wr_addr;
        av_writedata  = wr_data;
        av_byteenable = wr_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      slot_q     <= '0;
      busy_q     <= 1'b0;
    end else if (burst_start) begin
      base_q     <= disp_addr;
      len_q      <= {1'b0, disp_len};
      issued_q   <= '0;
      received_q <= '0;
      slot_q     <= '0;
      busy_q     <= ~len_zero;
    end else begin
      if (rd_fire) begin
        issued_q <= issued_inc;
        slot_q   <= (state_d == WR_ISSUE) ? '0 : slot_inc;
      end
      if (ret_ok)     received_q <= received_q + CNT_W'(1);
      if (drain_exit) busy_q     <= 1'b0;
    end
  end

  // An accept and a return in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      case ({rd_fire, ret_ok})
        2'b10:   pend_q <= pend_q + PEND_W'(1);
        2'b01:   pend_q <= pend_q - PEND_W'(1);
        default: pend_q <= pend_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      valid_q <= ret_ok;
      if (ret_ok) data_q <= av_readdata;
      done_q  <= drain_exit | (burst_start & len_zero);
      ack_q   <= wr_fire;
    end
  end

  assign disp_busy  = busy_q;
  assign disp_data  = data_q;
  assign disp_valid = valid_q;
  assign disp_done  = done_q;
  assign wr_ack     = ack_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Bench for sdram_access_arbiter: an Avalon controller model with random stalls
// and latency returns address-derived data; a scoreboard checks display words.
module tb_sdram_access_arbiter;
  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 32;
  localparam int BURST_W  = 10;
  localparam int MAX_PEND = 7;
  localparam int WR_SLOT  = 64;
  localparam int BE_W     = DATA_W / 8;

  logic                clk;
  logic                rst_n;
  logic                disp_req;
  logic [ADDR_W-1:0]   disp_addr;
  logic [BURST_W-1:0]  disp_len;
  logic                disp_busy;
  logic [DATA_W-1:0]   disp_data;
  logic                disp_valid;
  logic                disp_done;
  logic                wr_req;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [BE_W-1:0]     wr_be;
  logic                wr_ack;
  logic [ADDR_W-1:0]   av_address;
  logic                av_read;
  logic                av_write;
  logic [DATA_W-1:0]   av_writedata;
  logic [BE_W-1:0]     av_byteenable;
  logic                av_waitrequest;
  logic [DATA_W-1:0]   av_readdata;
  logic                av_readdatavalid;

  sdram_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
    .MAX_PEND(MAX_PEND), .WR_SLOT(WR_SLOT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_len(disp_len),
    .disp_busy(disp_busy), .disp_data(disp_data), .disp_valid(disp_valid),
    .disp_done(disp_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ack(wr_ack),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [DATA_W-1:0] expData[$];
  logic [ADDR_W-1:0] retAddr[$];
  int                retDue[$];

  logic [ADDR_W-1:0] expBase = '0;
  int burstAcc = 0, accTotal = 0, retTotal = 0, peakOut = 0;
  int latency = 2, waitPct = 0, stallIdx = -1, stallLen = 0, stallCnt = 0;
  int doneCnt = 0, ackCnt = 0, wrCnt = 0, wrAtRead = -1, doneAtWr = -1;
  int wrCycle = -1, ackDue = -10, validCnt = 0;
  bit strayReq = 1'b0;

  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    return {a[6:0], a} ^ 32'hC3A5_1E0F;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller model plus output monitor; all decisions are made on the falling edge.
  initial begin
    logic w;
    logic [ADDR_W-1:0] expAddr;
    av_waitrequest   = 1'b0;
    av_readdatavalid = 1'b0;
    av_readdata      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        retAddr.delete();
        retDue.delete();
        accTotal = 0;
        retTotal = 0;
        av_waitrequest   = 1'b0;
        av_readdatavalid = 1'b0;
        av_readdata      = '0;
      end else begin
        if (av_read || av_write)
          checkOutput("rw_exclusive", 64'(av_read & av_write), 64'd0);
        if (disp_valid) begin
          validCnt++;
          if (expData.size() == 0) checkOutput("spurious_valid", 64'(disp_valid), 64'd0);
          else                     checkOutput("read_data", 64'(disp_data), 64'(expData.pop_front()));
        end
        if (disp_done) doneCnt++;
        if (wr_ack || ackDue == cyc) begin
          checkOutput("wr_ack_pulse", 64'(wr_ack), 64'(ackDue == cyc));
          if (wr_ack) begin
            ackCnt++;
            wr_req = 1'b0;
          end
        end

        w = 1'b0;
        if (av_read && burstAcc == stallIdx && stallCnt < stallLen) begin
          w = 1'b1;
          stallCnt++;
        end else if ((av_read || av_write) && int'($urandom_range(99)) < waitPct) begin
          w = 1'b1;
        end
        av_waitrequest = w;

        if (av_read) begin
          expAddr = expBase + ADDR_W'(burstAcc);
          checkOutput("rd_address", 64'(av_address), 64'(expAddr));
          if (!w) begin
            retAddr.push_back(av_address);
            retDue.push_back(cyc + latency);
            burstAcc++;
            accTotal++;
            if (accTotal - retTotal > peakOut) peakOut = accTotal - retTotal;
          end
        end
        if (av_write && !w) begin
          checkOutput("wr_address", 64'(av_address), 64'(wr_addr));
          checkOutput("wr_data", 64'(av_writedata), 64'(wr_data));
          checkOutput("wr_be", 64'(av_byteenable), 64'(wr_be));
          wrCnt++;
          wrAtRead = burstAcc;
          doneAtWr = doneCnt;
          wrCycle  = cyc;
          ackDue   = cyc + 1;
        end

        if (retDue.size() > 0 && retDue[0] <= cyc) begin
          av_readdatavalid = 1'b1;
          av_readdata      = memWord(retAddr.pop_front());
          retDue.delete(0);
          retTotal++;
        end else if (strayReq) begin
          av_readdatavalid = 1'b1;
          av_readdata      = $urandom;
          strayReq         = 1'b0;
        end else begin
          av_readdatavalid = 1'b0;
          av_readdata      = '0;
        end
      end
    end
  end

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_ctrl"}, 64'({disp_busy, disp_valid, disp_done, wr_ack, av_read, av_write}), 64'd0);
    checkOutput({name, "_addr"}, 64'(av_address), 64'd0);
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int len, input int lat,
                               input int wp, input bit withWrite);
    logic [ADDR_W-1:0] a;
    int expSlot;
    latency = lat; waitPct = wp; burstAcc = 0; expBase = base; peakOut = 0;
    doneCnt = 0; ackCnt = 0; wrCnt = 0; wrAtRead = -1; doneAtWr = -1;
    for (int i = 0; i < len; i++) begin
      a = base + ADDR_W'(i);
      expData.push_back(memWord(a));
    end
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = base; disp_len = BURST_W'(len);
    if (withWrite) begin
      wr_req = 1'b1; wr_addr = ADDR_W'($urandom); wr_data = $urandom; wr_be = BE_W'($urandom);
    end
    @(posedge clk); #1;
    disp_req = 1'b0; disp_addr = ADDR_W'($urandom); disp_len = BURST_W'($urandom);
    if (len == 0) checkOutput("zero_len_done", 64'(disp_done), 64'd1);
    else          checkOutput("busy_after_start", 64'(disp_busy), 64'd1);
    for (int t = 0; t < 3000 && !(doneCnt >= 1 && (!withWrite || ackCnt >= 1)); t++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_count", 64'(doneCnt), 64'd1);
    checkOutput("words_left", 64'(expData.size()), 64'd0);
    checkOutput("reads_issued", 64'(burstAcc), 64'(len));
    checkOutput("busy_after_done", 64'(disp_busy), 64'd0);
    checkOutput("peak_within_limit", 64'(peakOut <= MAX_PEND), 64'd1);
    if (withWrite) begin
      expSlot = (len >= WR_SLOT) ? WR_SLOT : len;
      checkOutput("write_count", 64'(wrCnt), 64'd1);
      checkOutput("ack_count", 64'(ackCnt), 64'd1);
      checkOutput("write_position", 64'(wrAtRead), 64'(expSlot));
      checkOutput("write_vs_done", 64'(doneAtWr), 64'((len >= WR_SLOT) ? 0 : 1));
    end
    expData.delete();
  endtask

  task automatic applyWriteOnly();
    int reqCyc;
    wrCnt = 0; ackCnt = 0; waitPct = 0; wrCycle = -1;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = ADDR_W'($urandom); wr_data = $urandom; wr_be = BE_W'($urandom);
    reqCyc = cyc;
    for (int t = 0; t < 50 && ackCnt == 0; t++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput("wr_only_count", 64'(wrCnt), 64'd1);
    checkOutput("wr_only_acks", 64'(ackCnt), 64'd1);
    // Request seen on the next edge, av_write visible one cycle after that.
    checkOutput("wr_only_latency", 64'(wrCycle - reqCyc), 64'd2);
    checkOutput("wr_only_busy", 64'(disp_busy), 64'd0);
  endtask

  initial begin
    int v0;
    rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0; disp_len = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset_data", 64'(disp_data), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] basic burst");
    applyStimulus(25'h100, 8, 2, 0, 1'b0);

    $display("[TB] waitrequest stall on second read");
    stallIdx = 1; stallLen = 3; stallCnt = 0;
    applyStimulus(25'h100, 8, 2, 0, 1'b0);
    checkOutput("stall_cycles", 64'(stallCnt), 64'd3);
    stallIdx = -1;

    $display("[TB] long latency, outstanding limit");
    applyStimulus(25'h2000, 16, 20, 0, 1'b0);
    checkOutput("peak_outstanding", 64'(peakOut), 64'(MAX_PEND));

    $display("[TB] long burst with write slot");
    applyStimulus(25'h40000, 200, 4, 15, 1'b1);

    $display("[TB] simultaneous read and write request");
    applyStimulus(25'h300, 10, 3, 0, 1'b1);

    $display("[TB] write alone");
    applyWriteOnly();

    $display("[TB] zero-length burst");
    applyStimulus(25'h500, 0, 2, 0, 1'b0);

    $display("[TB] address wrap");
    applyStimulus(25'h1FF_FFFC, 8, 3, 20, 1'b0);

    $display("[TB] stray return while idle");
    v0 = validCnt;
    strayReq = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("stray_dropped", 64'(validCnt - v0), 64'd0);

    $display("[TB] reset mid-burst");
    latency = 5; waitPct = 10; burstAcc = 0; expBase = 25'h7000;
    for (int i = 0; i < 100; i++) expData.push_back(memWord(25'h7000 + ADDR_W'(i)));
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = 25'h7000; disp_len = BURST_W'(100);
    @(posedge clk); #1;
    disp_req = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkIdleOutputs("abort");
    expData.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(25'h7100, 12, 3, 10, 1'b0);

    $display("[TB] randomized bursts");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(ADDR_W'($urandom), int'($urandom_range(1, 40)), int'($urandom_range(1, 12)),
                    int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
